scr1_dmem_tcm_router: RTL
=========================

Name: scr1_dmem_tcm_router

Overview:
Sits between the core data memory interface and its two targets: the TCM data port and the external memory bridge. Decodes each request address, forwards it to one target, and tracks one outstanding transaction. Muxes the response back to the core. A watchdog on the external path turns a hung bus into an error response.

Parameters:
TCM_ADDR_MASK, `SCR1_DMEM_AWIDTH'hFFFF0000, address bits compared for the TCM hit
TCM_ADDR_PATTERN, `SCR1_DMEM_AWIDTH'h00480000, TCM hit when (dmem_addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN
EXT_TIMEOUT, 256, number of cycles an external request may wait for its response; must be at least 2

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
dmem_req_ack  output  1  core request accepted this cycle
dmem_req  input  1  core request valid
dmem_cmd  input  type_scr1_mem_cmd_e  read or write
dmem_width  input  type_scr1_mem_width_e  access size
dmem_addr  input  `SCR1_DMEM_AWIDTH  byte address
dmem_wdata  input  `SCR1_DMEM_DWIDTH  write data
dmem_rdata  output  `SCR1_DMEM_DWIDTH  read data, valid when dmem_resp is RDY_OK
dmem_resp  output  type_scr1_mem_resp_e  core response
tcm_req_ack, ext_req_ack  input  1 each  target accepted the request
tcm_req, ext_req  output  1 each  forwarded request
tcm_cmd, ext_cmd  output  type_scr1_mem_cmd_e  copy of dmem_cmd
tcm_width, ext_width  output  type_scr1_mem_width_e  copy of dmem_width
tcm_addr, ext_addr  output  `SCR1_DMEM_AWIDTH  copy of dmem_addr
tcm_wdata, ext_wdata  output  `SCR1_DMEM_DWIDTH  copy of dmem_wdata
tcm_rdata, ext_rdata  input  `SCR1_DMEM_DWIDTH  target read data
tcm_resp, ext_resp  input  type_scr1_mem_resp_e  target response

Behaviour:
- Clock is clk. Reset is asynchronous and active-low on rst_n, as already decided.
- Reset state: fsm = IDLE, sel_r = TCM, timeout counter = 0.
- Outputs during reset: tcm_req = 0, ext_req = 0, dmem_req_ack = 0, dmem_resp = NOTRDY, dmem_rdata = 0.
- Decode (combinational on dmem_addr): hit_tcm = ((dmem_addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN). Every miss goes to ext.
- can_accept: fsm == IDLE, or fsm == WAIT and the response from the sel_r target is not NOTRDY in the same cycle. can_accept = 0 in DRAIN.
- Forwarding:
  - tcm_req = dmem_req & can_accept & hit_tcm; ext_req = dmem_req & can_accept & ~hit_tcm.
  - cmd, width, addr and wdata go to both targets unconditionally.
  - dmem_req_ack = can_accept & (hit_tcm ? tcm_req_ack : ext_req_ack).
  - Accept = dmem_req & dmem_req_ack.
- IDLE:
  - dmem_resp = NOTRDY, dmem_rdata = 0.
  - On accept: go to WAIT, sel_r <= target, counter <= 0.
- WAIT:
  - dmem_resp and dmem_rdata are muxed from the sel_r target.
  - On completion (target resp is RDY_OK or RDY_ER): with a same-cycle accept, stay in WAIT and reload sel_r and counter (back-to-back, no bubble); otherwise go to IDLE.
  - TCM round trip is therefore 1 cycle, and throughput is 1 access per cycle.
- Watchdog (WAIT with sel_r = EXT only):
  - Counter increments every cycle ext_resp = NOTRDY.
  - When it reaches EXT_TIMEOUT-1: dmem_resp = RDY_ER and dmem_rdata = 0 that cycle, then go to DRAIN.
  - No new accept is allowed in the timeout cycle.
- DRAIN:
  - dmem_resp = NOTRDY, all target reqs = 0, dmem_req_ack = 0.
  - The first ext_resp != NOTRDY is discarded and the fsm returns to IDLE.
  - A core request held during DRAIN is accepted once the fsm is in IDLE.
- A target RDY_ER is passed through unchanged. The router makes no width or alignment checks.
- A TCM target never triggers a timeout.
- Reset mid-transaction drops the outstanding access. Any late target response after reset is ignored because the fsm is in IDLE.

Decomposition:
- Shared package: the fsm state enum type_scr1_dmem_rtr_fsm_e {IDLE, WAIT, DRAIN} and the target enum type_scr1_dmem_rtr_sel_e {TCM, EXT}, alongside the existing memif types.
- Address constants come from the arch description defines.
- No sub-module. The watchdog counter is inline, log2(EXT_TIMEOUT) bits wide.

Test Plan:
1. Read 0x00480010 with TCM answering RDY_OK data 0x1122334455667788 one cycle later -> tcm_req=1, ext_req=0, dmem_resp=RDY_OK with the same data on cycle +1, fsm back to IDLE.
2. Back-to-back TCM reads 0x00480000 then 0x00480008, dmem_req held -> dmem_req_ack high on consecutive cycles, two RDY_OK responses on consecutive cycles, no bubble.
3. Write 0x20000000 with ext_req_ack low for 3 cycles -> dmem_req_ack stays low for 3 cycles, accepted on cycle 4, ext response RDY_OK muxed to core.
4. Ext read with EXT_TIMEOUT=8 and ext_resp held NOTRDY -> dmem_resp=RDY_ER on cycle 8; a core request is blocked until the late ext RDY_OK is discarded, then accepted.
5. Ext returns RDY_ER -> core sees RDY_ER the same cycle and the fsm goes to IDLE.
6. rst_n asserted while in WAIT for ext -> outputs return to reset values immediately; a post-reset TCM read completes normally.

Source files
------------

// File: rtl/scr1_dmem_tcm_router_pkg.sv
// rtl/scr1_dmem_tcm_router_pkg.sv - memory interface types, arch constants and router enums
package scr1_dmem_tcm_router_pkg;

  // Data memory bus geometry
  localparam int SCR1_DMEM_AWIDTH = 32;
  localparam int SCR1_DMEM_DWIDTH = 64;

  // Default TCM window in the data address map
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_TCM_ADDR_MASK    = 32'hFFFF0000;
  localparam logic [SCR1_DMEM_AWIDTH-1:0] SCR1_DMEM_TCM_ADDR_PATTERN = 32'h00480000;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_DWORD = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  // Router transaction state
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    DRAIN = 2'b10
  } type_scr1_dmem_rtr_fsm_e;

  // Target owning the outstanding transaction
  typedef enum logic {
    TCM = 1'b0,
    EXT = 1'b1
  } type_scr1_dmem_rtr_sel_e;

endpackage

// File: rtl/scr1_dmem_tcm_router.sv
// rtl/scr1_dmem_tcm_router.sv - routes core data accesses to TCM or external bridge with ext watchdog
module scr1_dmem_tcm_router
  import scr1_dmem_tcm_router_pkg::*;
#(
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_MASK    = SCR1_DMEM_TCM_ADDR_MASK,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] TCM_ADDR_PATTERN = SCR1_DMEM_TCM_ADDR_PATTERN,
  parameter int                          EXT_TIMEOUT      = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // core side
  output logic                          dmem_req_ack,
  input  logic                          dmem_req,
  input  type_scr1_mem_cmd_e            dmem_cmd,
  input  type_scr1_mem_width_e          dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   dmem_wdata,
  output logic [SCR1_DMEM_DWIDTH-1:0]   dmem_rdata,
  output type_scr1_mem_resp_e           dmem_resp,
  // TCM target
  input  logic                          tcm_req_ack,
  output logic                          tcm_req,
  output type_scr1_mem_cmd_e            tcm_cmd,
  output type_scr1_mem_width_e          tcm_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   tcm_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   tcm_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   tcm_rdata,
  input  type_scr1_mem_resp_e           tcm_resp,
  // external memory bridge
  input  logic                          ext_req_ack,
  output logic                          ext_req,
  output type_scr1_mem_cmd_e            ext_cmd,
  output type_scr1_mem_width_e          ext_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   ext_addr,
  output logic [SCR1_DMEM_DWIDTH-1:0]   ext_wdata,
  input  logic [SCR1_DMEM_DWIDTH-1:0]   ext_rdata,
  input  type_scr1_mem_resp_e           ext_resp
);

  localparam int              CNT_W   = (EXT_TIMEOUT > 2) ? $clog2(EXT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(EXT_TIMEOUT - 1);

  type_scr1_dmem_rtr_fsm_e     fsm;
  type_scr1_dmem_rtr_sel_e     sel_r;
  logic [CNT_W-1:0]            cnt;

  logic                        hit_tcm;
  type_scr1_dmem_rtr_sel_e     sel_new;
  type_scr1_mem_resp_e         sel_resp;
  logic [SCR1_DMEM_DWIDTH-1:0] sel_rdata;
  logic                        resp_done;
  logic                        timeout;
  logic                        can_accept;
  logic                        accept;

  assign hit_tcm   = ((dmem_addr & TCM_ADDR_MASK) == TCM_ADDR_PATTERN);
  assign sel_new   = hit_tcm ? TCM : EXT;
  assign sel_resp  = (sel_r == TCM) ? tcm_resp  : ext_resp;
  assign sel_rdata = (sel_r == TCM) ? tcm_rdata : ext_rdata;
  assign resp_done = (sel_resp != SCR1_MEM_RESP_NOTRDY);

  // Watchdog fires only while an ext access is still silent at the last allowed cycle
  assign timeout = (fsm == WAIT) && (sel_r == EXT) &&
                   (ext_resp == SCR1_MEM_RESP_NOTRDY) && (cnt == CNT_MAX);

  // rst_n gating keeps target requests and the ack quiet while reset is held
  assign can_accept = rst_n && ((fsm == IDLE) || ((fsm == WAIT) && resp_done));

  assign tcm_req      = dmem_req & can_accept & hit_tcm;
  assign ext_req      = dmem_req & can_accept & ~hit_tcm;
  assign dmem_req_ack = can_accept & (hit_tcm ? tcm_req_ack : ext_req_ack);
  assign accept       = dmem_req & dmem_req_ack;

  assign tcm_cmd   = dmem_cmd;
  assign tcm_width = dmem_width;
  assign tcm_addr  = dmem_addr;
  assign tcm_wdata = dmem_wdata;
  assign ext_cmd   = dmem_cmd;
  assign ext_width = dmem_width;
  assign ext_addr  = dmem_addr;
  assign ext_wdata = dmem_wdata;

  // Core response mux: only WAIT forwards a target response, timeout overrides with an error
  always_comb begin
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (fsm == WAIT) begin
      if (timeout) begin
        dmem_resp  = SCR1_MEM_RESP_RDY_ER;
        dmem_rdata = '0;
      end else begin
        dmem_resp  = sel_resp;
        dmem_rdata = sel_rdata;
      end
    end
  end

  // Transaction tracker: one outstanding access, back-to-back reload, watchdog and drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm   <= IDLE;
      sel_r <= TCM;
      cnt   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            fsm   <= WAIT;
            sel_r <= sel_new;
            cnt   <= '0;
          end
        end
        WAIT: begin
          if (timeout) begin
            fsm <= DRAIN;
          end else if (resp_done) begin
            if (accept) begin
              sel_r <= sel_new;
              cnt   <= '0;
            end else begin
              fsm <= IDLE;
            end
          end else if (sel_r == EXT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          // The hung access eventually answers; swallow that one response
          if (ext_resp != SCR1_MEM_RESP_NOTRDY) begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
